// File: rtl/bp_me_pkg.sv
// -----------------------------------------------------------------------------
// bp_me_pkg
// Shared types for the CCE memory interface responder:
//   - physical address / block geometry localparams
//   - memory message type and size enums, payload and message structs
//   - responder FSM state enum
//   - size-to-byte-count, size-to-byte-mask and offset-alignment helpers
// -----------------------------------------------------------------------------
package bp_me_pkg;

  localparam int PADDR_W        = 40;
  localparam int CCE_BLOCK_W    = 512;
  localparam int BLOCK_BYTES    = CCE_BLOCK_W / 8;
  localparam int BLOCK_OFFSET_W = $clog2(BLOCK_BYTES);
  localparam int LCE_ID_W       = 4;
  localparam int LCE_ASSOC      = 8;
  localparam int WAY_ID_W       = $clog2(LCE_ASSOC);

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3
  } bp_cce_mem_type_e;

  // Access size is 1 << size bytes; sizes above the block are clamped.
  typedef enum logic [2:0] {
    e_mem_size_1   = 3'd0,
    e_mem_size_2   = 3'd1,
    e_mem_size_4   = 3'd2,
    e_mem_size_8   = 3'd3,
    e_mem_size_16  = 3'd4,
    e_mem_size_32  = 3'd5,
    e_mem_size_64  = 3'd6,
    e_mem_size_128 = 3'd7
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [LCE_ID_W-1:0] lce_id;
    logic [WAY_ID_W-1:0] way_id;
    logic                prefetch;
    logic                uncached;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_type_e     msg_type;
    logic [PADDR_W-1:0]   addr;
    bp_mem_msg_size_e     size;
    bp_cce_mem_payload_s  payload;
    logic [CCE_BLOCK_W-1:0] data;
  } bp_cce_mem_msg_s;

  localparam int CCE_MEM_MSG_W = $bits(bp_cce_mem_msg_s);

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_wait  = 2'd1,
    e_resp  = 2'd2
  } bp_me_mem_responder_state_e;

  function automatic int size_to_bytes(input bp_mem_msg_size_e size);
    return (int'(size) >= BLOCK_OFFSET_W) ? BLOCK_BYTES : (1 << int'(size));
  endfunction

  // Right-aligned byte mask covering the access size.
  function automatic logic [BLOCK_BYTES-1:0] size_to_mask(input bp_mem_msg_size_e size);
    logic [BLOCK_BYTES-1:0] mask;
    int n;
    n = size_to_bytes(size);
    for (int i = 0; i < BLOCK_BYTES; i++) mask[i] = (i < n);
    return mask;
  endfunction

  // Byte offset within the block, aligned down to the access size.
  function automatic logic [BLOCK_OFFSET_W-1:0] block_offset(
    input logic [BLOCK_OFFSET_W-1:0] addr_lo,
    input bp_mem_msg_size_e          size
  );
    logic [BLOCK_OFFSET_W-1:0] align;
    align = BLOCK_OFFSET_W'(size_to_bytes(size) - 1);
    return addr_lo & ~align;
  endfunction

endpackage

// File: rtl/bp_me_mem_responder_ram.sv
// -----------------------------------------------------------------------------
// bp_me_mem_responder_ram
// Byte-masked single-port block RAM, els_p x width_p, no reset on contents.
// One access per cycle when i_en is high: a write commits the bytes selected
// by i_wmask, a read captures the whole row into o_rdata, which then holds
// until the next read.
// Ports:
//   i_clk    clock
//   i_en     access enable
//   i_we     1 = write, 0 = read
//   i_addr   row index
//   i_wmask  per-byte write enable
//   i_wdata  write data (byte lanes already in position)
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module bp_me_mem_responder_ram #(
  parameter int els_p   = 1024,
  parameter int width_p = 512,
  localparam int ADDR_W  = $clog2(els_p),
  localparam int BYTES_W = width_p / 8
) (
  input  logic               i_clk,
  input  logic               i_en,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [BYTES_W-1:0] i_wmask,
  input  logic [width_p-1:0] i_wdata,
  output logic [width_p-1:0] o_rdata
);

  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BYTES_W; b++) begin
          if (i_wmask[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bp_me_mem_responder.sv
// -----------------------------------------------------------------------------
// bp_me_mem_responder
// Single-outstanding responder for the CCE mem_cmd/mem_resp channel. Commands
// are serviced from an internal block RAM on the accept edge, and the response
// is presented after a programmable latency.
//
// Handshake: a command transfers on a rising edge where mem_cmd_v_i and
// mem_cmd_ready_o are both high; a response is presented with mem_resp_v_o
// and held unchanged until the consumer pulses mem_resp_yumi_i, which is only
// honoured while mem_resp_v_o is high.
//
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   mem_cmd_i/_v_i     command message and valid
//   mem_cmd_ready_o    ready to accept (only in e_ready, once out of reset)
//   mem_resp_o/_v_o    response message and valid
//   mem_resp_yumi_i    consumer accepts the response
//   err_o              sticky: an out-of-range or undefined command was seen
//   dbg_state_o        current FSM state (bp_me_mem_responder_state_e)
//
// Build option: BP_ME_MEM_RESPONDER_RANDOM_LATENCY_EN -- when defined, each
// command's latency is drawn from a free-running 8-bit LFSR in 1..latency_p.
// -----------------------------------------------------------------------------
module bp_me_mem_responder
  import bp_me_pkg::*;
#(
  parameter int                 mem_els_p    = 1024,
  parameter int                 latency_p    = 4,
  parameter logic [PADDR_W-1:0] mem_offset_p = PADDR_W'(32'h8000_0000)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [CCE_MEM_MSG_W-1:0] mem_cmd_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_o,
  output logic [CCE_MEM_MSG_W-1:0] mem_resp_o,
  output logic                     mem_resp_v_o,
  input  logic                     mem_resp_yumi_i,
  output logic                     err_o,
  output logic [1:0]               dbg_state_o
);

  localparam int IDX_W = $clog2(mem_els_p);

  // ---------------------------------------------------------------- decode
  bp_cce_mem_msg_s            w_cmd;
  logic                       w_accept;
  logic [PADDR_W-1:0]         w_rel;
  logic [PADDR_W-1:0]         w_blk;
  logic                       w_in_range;
  logic                       w_is_rd;
  logic                       w_is_wr;
  logic                       w_valid_access;
  logic [BLOCK_OFFSET_W-1:0]  w_off;
  logic [BLOCK_BYTES-1:0]     w_wmask;
  logic [CCE_BLOCK_W-1:0]     w_wdata;
  logic [7:0]                 w_lat_load;

  assign w_cmd      = bp_cce_mem_msg_s'(mem_cmd_i);
  assign w_accept   = mem_cmd_v_i & mem_cmd_ready_o;
  assign w_rel      = w_cmd.addr - mem_offset_p;
  assign w_blk      = w_rel >> BLOCK_OFFSET_W;
  assign w_in_range = (w_cmd.addr >= mem_offset_p) && (w_blk < PADDR_W'(mem_els_p));
  assign w_is_rd    = (w_cmd.msg_type == e_cce_mem_rd) || (w_cmd.msg_type == e_cce_mem_uc_rd);
  assign w_is_wr    = (w_cmd.msg_type == e_cce_mem_wr) || (w_cmd.msg_type == e_cce_mem_uc_wr);
  // Undefined message types take the out-of-range path.
  assign w_valid_access = w_in_range & (w_is_rd | w_is_wr);

  assign w_off   = block_offset(w_cmd.addr[BLOCK_OFFSET_W-1:0], w_cmd.size);
  // Payload bytes arrive right-aligned; move them to the addressed lanes.
  assign w_wmask = size_to_mask(w_cmd.size) << w_off;
  assign w_wdata = w_cmd.data << {w_off, 3'b000};

  // --------------------------------------------------------------- latency
`ifdef BP_ME_MEM_RESPONDER_RANDOM_LATENCY_EN
  logic [7:0] r_lfsr;

  // x^8 + x^6 + x^5 + x^4 + 1, advancing every cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_lat_load = r_lfsr % 8'(latency_p);
`else
  assign w_lat_load = 8'(latency_p - 1);
`endif

  // ------------------------------------------------------------------ RAM
  logic [CCE_BLOCK_W-1:0] w_rdata;

  bp_me_mem_responder_ram #(
    .els_p   (mem_els_p),
    .width_p (CCE_BLOCK_W)
  ) u_ram (
    .i_clk   (clk_i),
    .i_en    (w_accept & w_valid_access),
    .i_we    (w_is_wr),
    .i_addr  (w_blk[IDX_W-1:0]),
    .i_wmask (w_wmask),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // ------------------------------------------------------------------ FSM
  bp_me_mem_responder_state_e r_state;
  logic [7:0]                 r_cnt;
  logic                       r_live;
  logic                       r_err;
  logic                       r_oor;
  bp_cce_mem_type_e           r_type;
  logic [PADDR_W-1:0]         r_addr;
  bp_mem_msg_size_e           r_size;
  bp_cce_mem_payload_s        r_payload;
  logic [BLOCK_OFFSET_W-1:0]  r_off;

  // r_cnt holds the cycles still to wait before e_resp. A zero load skips
  // e_wait entirely so a latency of 1 lands the response on the next cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= e_ready;
      r_cnt     <= '0;
      r_live    <= 1'b0;
      r_err     <= 1'b0;
      r_oor     <= 1'b0;
      r_type    <= e_cce_mem_rd;
      r_addr    <= '0;
      r_size    <= e_mem_size_1;
      r_payload <= '0;
      r_off     <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept && !w_valid_access) r_err <= 1'b1;
      case (r_state)
        e_ready: begin
          if (w_accept) begin
            r_oor     <= ~w_valid_access;
            r_type    <= w_cmd.msg_type;
            r_addr    <= w_cmd.addr;
            r_size    <= w_cmd.size;
            r_payload <= w_cmd.payload;
            r_off     <= w_off;
            r_cnt     <= w_lat_load;
            r_state   <= (w_lat_load == 8'd0) ? e_resp : e_wait;
          end
        end
        e_wait: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= e_resp;
        end
        e_resp: begin
          if (mem_resp_yumi_i) r_state <= e_ready;
        end
        default: r_state <= e_ready;
      endcase
    end
  end

  assign mem_cmd_ready_o = r_live & (r_state == e_ready);
  assign mem_resp_v_o    = (r_state == e_resp);
  assign err_o           = r_err;
  assign dbg_state_o     = r_state;

  // ------------------------------------------------------------- response
  // The RAM output and the captured header only change on the next accept,
  // so the response is stable for as long as it is held.
  logic [BLOCK_BYTES-1:0] w_byte_mask;
  logic [CCE_BLOCK_W-1:0] w_shifted;
  logic [CCE_BLOCK_W-1:0] w_uc_data;
  logic [CCE_BLOCK_W-1:0] w_resp_data;
  bp_cce_mem_msg_s        w_resp;

  always_comb begin
    w_byte_mask = size_to_mask(r_size);
    w_shifted   = w_rdata >> {r_off, 3'b000};
    w_uc_data   = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (w_byte_mask[i]) w_uc_data[i*8 +: 8] = w_shifted[i*8 +: 8];
    end
  end

  always_comb begin
    w_resp_data = '0;
    if (!r_oor) begin
      case (r_type)
        e_cce_mem_rd:    w_resp_data = w_rdata;
        e_cce_mem_uc_rd: w_resp_data = w_uc_data;
        default:         w_resp_data = '0;
      endcase
    end
  end

  always_comb begin
    w_resp          = '0;
    w_resp.msg_type = r_type;
    w_resp.addr     = r_addr;
    w_resp.size     = r_size;
    w_resp.payload  = r_payload;
    w_resp.data     = w_resp_data;
  end

  assign mem_resp_o = w_resp;

endmodule
